// File: rtl/screen_framebuffer.sv
// Double-buffered 64x64 RGB pixel store: the CPU fills the back bank, the scan driver reads the front bank.
// Banks are exchanged only on frame_end, and a hardware fill can paint the whole back bank.
module screen_framebuffer #(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = 64,
    parameter int BIT_DEPTH = 4,
    localparam int HALF = NUM_COLS * NUM_ROWS / 2,
    localparam int AW   = $clog2(NUM_COLS * NUM_ROWS),
    localparam int PW   = 3 * BIT_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_data,
    input  logic          clear_req,
    input  logic [PW-1:0] clear_color,
    input  logic          swap_req,
    output logic          busy,
    output logic          swap_pending,
    input  logic          frame_end,
    input  logic          rd_en,
    input  logic [AW-2:0] rd_addr,
    output logic [PW-1:0] rd_rgb0,
    output logic [PW-1:0] rd_rgb1,
    output logic          rd_valid,
    output logic          front_sel
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SWAP_WAIT
    } state_t;

    localparam logic [AW-2:0] PTR_LAST = (AW-1)'(HALF - 1);

    state_t        state;
    state_t        next_state;
    logic [AW-2:0] ptr;
    logic [PW-1:0] fill_color;

    logic [PW-1:0] bank0_top [HALF];
    logic [PW-1:0] bank0_bot [HALF];
    logic [PW-1:0] bank1_top [HALF];
    logic [PW-1:0] bank1_bot [HALF];

    logic          wr_accept;
    logic          top_we;
    logic          bot_we;
    logic [AW-2:0] mem_idx;
    logic [PW-1:0] mem_data;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    next_state = CLEAR;
                end else if (swap_req) begin
                    next_state = SWAP_WAIT;
                end
            end
            CLEAR: begin
                if (ptr == PTR_LAST) begin
                    next_state = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (frame_end) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write port shared by CPU writes and the fill engine; nothing is written while reset is held.
    always_comb begin
        wr_accept = wr_valid & wr_ready;
        top_we    = 1'b0;
        bot_we    = 1'b0;
        mem_idx   = wr_addr[AW-2:0];
        mem_data  = wr_data;
        if (state == CLEAR) begin
            mem_idx  = ptr;
            mem_data = fill_color;
            top_we   = 1'b1;
            bot_we   = 1'b1;
        end else if (wr_accept) begin
            top_we = ~wr_addr[AW-1];
            bot_we = wr_addr[AW-1];
        end
        if (!reset) begin
            top_we = 1'b0;
            bot_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            front_sel    <= 1'b0;
            busy         <= 1'b0;
            swap_pending <= 1'b0;
            wr_ready     <= 1'b0;
            ptr          <= '0;
            fill_color   <= '0;
        end else begin
            state        <= next_state;
            busy         <= (next_state != IDLE);
            swap_pending <= (next_state == SWAP_WAIT);
            wr_ready     <= (next_state == IDLE);
            if (state == IDLE && clear_req) begin
                fill_color <= clear_color;
                ptr        <= '0;
            end else if (state == CLEAR) begin
                ptr <= ptr + 1'b1;
            end
            if (state == SWAP_WAIT && frame_end) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // The back bank is always the one not on display.
    always_ff @(posedge clk) begin
        if (top_we && !front_sel) bank1_top[mem_idx] <= mem_data;
        if (bot_we && !front_sel) bank1_bot[mem_idx] <= mem_data;
        if (top_we && front_sel)  bank0_top[mem_idx] <= mem_data;
        if (bot_we && front_sel)  bank0_bot[mem_idx] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_rgb0  <= '0;
            rd_rgb1  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_rgb0 <= front_sel ? bank1_top[rd_addr] : bank0_top[rd_addr];
                rd_rgb1 <= front_sel ? bank1_bot[rd_addr] : bank0_bot[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_screen_framebuffer.sv
// Directed bench for screen_framebuffer: read pairs are checked by a scoreboard monitor,
// control outputs are checked inline after each clock.
module tb_screen_framebuffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [11:0] wr_data;
    logic        clear_req;
    logic [11:0] clear_color;
    logic        swap_req;
    logic        busy;
    logic        swap_pending;
    logic        frame_end;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [11:0] rd_rgb0;
    logic [11:0] rd_rgb1;
    logic        rd_valid;
    logic        front_sel;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;
    int          cnt;
    logic        seen;

    always #5 clk = ~clk;

    screen_framebuffer dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .swap_req     (swap_req),
        .busy         (busy),
        .swap_pending (swap_pending),
        .frame_end    (frame_end),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_rgb0      (rd_rgb0),
        .rd_rgb1      (rd_rgb1),
        .rd_valid     (rd_valid),
        .front_sel    (front_sel)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock: drive request inputs, wait for the edge, then drop the one-cycle pulses.
    task automatic applyStimulus(input logic wv, input logic [11:0] wa, input logic [11:0] wd,
                                 input logic clr, input logic swp, input logic fe,
                                 input logic [11:0] color);
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
        clear_req   = clr;
        swap_req    = swp;
        frame_end   = fe;
        clear_color = color;
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        swap_req  = 1'b0;
        frame_end = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic issueRead(input logic [10:0] addr, input logic [11:0] e0, input logic [11:0] e1);
        rd_en   = 1'b1;
        rd_addr = addr;
        exp_q.push_back({e0, e1});
    endtask

    task automatic doSwap();
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("rd_pair", {8'h00, rd_rgb0, rd_rgb1}, {8'h00, mon_exp});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; rd_en = 1'b0; rd_addr = '0;
        idle();
        idle();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_swap_pending", swap_pending, 0);
        checkOutput("reset_front_sel", front_sel, 0);
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_rd_rgb0", rd_rgb0, 0);
        checkOutput("reset_rd_rgb1", rd_rgb1, 0);
        checkOutput("reset_wr_ready", wr_ready, 0);
        reset = 1'b1;
        idle();
        checkOutput("post_reset_wr_ready", wr_ready, 1);

        // T1: basic write, swap, and dual-half read
        applyStimulus(1'b1, 12'h000, 12'hF00, 1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(1'b1, 12'h800, 12'h00F, 1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000);
        checkOutput("t1_swap_pending", swap_pending, 1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_wr_ready_wait", wr_ready, 0);
        idle();
        checkOutput("t1_still_pending", swap_pending, 1);
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000);
        checkOutput("t1_front_sel", front_sel, 1);
        checkOutput("t1_pending_clear", swap_pending, 0);
        checkOutput("t1_wr_ready", wr_ready, 1);
        issueRead(11'd0, 12'hF00, 12'h00F);
        idle();
        checkOutput("t1_rd_valid", rd_valid, 1);
        idle();
        checkOutput("t1_rd_valid_drop", rd_valid, 0);
        checkOutput("t1_rgb0_hold", rd_rgb0, 12'hF00);

        // T2: write held across a pending swap lands in the new back bank
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 12'h005, 12'h123, 1'b0, 1'b0, 1'b0, 12'h000);
            checkOutput("t2_wr_ready_low", wr_ready, 0);
            checkOutput("t2_swap_pending", swap_pending, 1);
        end
        applyStimulus(1'b1, 12'h005, 12'h123, 1'b0, 1'b0, 1'b1, 12'h000);
        checkOutput("t2_front_sel", front_sel, 0);
        checkOutput("t2_wr_ready_back", wr_ready, 1);
        applyStimulus(1'b1, 12'h005, 12'h123, 1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(1'b1, 12'h805, 12'h321, 1'b0, 1'b0, 1'b0, 12'h000);
        doSwap();
        checkOutput("t2_front_sel_again", front_sel, 1);
        issueRead(11'd5, 12'h123, 12'h321);
        idle();
        issueRead(11'd0, 12'hF00, 12'h00F);
        idle();
        idle();

        // T3: full fill of the back bank takes exactly HALF cycles
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 12'h0A5);
        checkOutput("t3_busy", busy, 1);
        checkOutput("t3_wr_ready", wr_ready, 0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            cnt++;
            idle();
        end
        checkOutput("t3_busy_cycles", cnt, 2048);
        doSwap();
        checkOutput("t3_front_sel", front_sel, 0);
        issueRead(11'd0, 12'h0A5, 12'h0A5);
        idle();
        issueRead(11'd1023, 12'h0A5, 12'h0A5);
        idle();
        issueRead(11'd2047, 12'h0A5, 12'h0A5);
        idle();
        idle();

        // T4: clear and swap together, clear wins
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0, 12'h5A0);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_no_pending", swap_pending, 0);
        seen = 1'b0;
        cnt  = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            if (swap_pending !== 1'b0) seen = 1'b1;
            cnt++;
            idle();
        end
        checkOutput("t4_pending_seen", seen, 0);
        checkOutput("t4_busy_cycles", cnt, 2048);
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000);
        checkOutput("t4_front_sel", front_sel, 0);

        // T5: reset in the middle of a fill
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 12'h333);
        repeat (100) idle();
        checkOutput("t5_busy_mid", busy, 1);
        reset = 1'b0;
        idle();
        checkOutput("t5_busy_reset", busy, 0);
        checkOutput("t5_front_sel_reset", front_sel, 0);
        checkOutput("t5_wr_ready_reset", wr_ready, 0);
        reset = 1'b1;
        idle();
        checkOutput("t5_wr_ready_release", wr_ready, 1);
        checkOutput("t5_busy_release", busy, 0);
        doSwap();
        checkOutput("t5_front_sel", front_sel, 1);
        issueRead(11'd0, 12'h333, 12'h333);
        idle();
        issueRead(11'd99, 12'h333, 12'h333);
        idle();
        issueRead(11'd100, 12'h5A0, 12'h5A0);
        idle();
        idle();

        // T6: a read on the swapping edge still sees the old front bank
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000);
        issueRead(11'd100, 12'h5A0, 12'h5A0);
        applyStimulus(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000);
        checkOutput("t6_front_sel", front_sel, 0);
        issueRead(11'd100, 12'h0A5, 12'h0A5);
        idle();
        idle();

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
